// File: rtl/uart_pkg.sv
// uart_pkg: UART constants and FSM state type shared by transmit and receive sides
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int CLKS_PER_BIT_DEF = 434;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with fall-through head, power-of-two depth
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd];
  always_ff @(posedge clk) if (do_push) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      level <= '0;
    end else begin
      wr <= do_push ? wr + 1'b1 : wr;
      rd <= do_pop ? rd + 1'b1 : rd;
      level <= (do_push && !do_pop) ? level + 1'b1 : (do_pop && !do_push) ? level - 1'b1 : level;
    end
  end
endmodule

// File: rtl/uart_cmd_tx.sv
// uart_cmd_tx: queues {ctrl,value} command bytes and sends them as 8N1 UART frames
module uart_cmd_tx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    ctrl_command_in,
  input  logic [3:0]                    value_command_in,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  uart_state_t state, nxt;
  logic [15:0] cnt;
  logic [2:0] idx;
  logic [UART_DATA_BITS-1:0] sh, head;
  logic full, empty, bit_done, pop;
  sync_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(cmd_valid && cmd_ready),
    .din({ctrl_command_in, value_command_in}), .pop(pop),
    .dout(head), .full(full), .empty(empty), .level(fifo_level)
  );
  assign cmd_ready = !full;
  assign tx_busy = state != IDLE;
  assign bit_done = state != IDLE && cnt == 16'(CLKS_PER_BIT - 1);
  assign pop = !empty && (state == IDLE || (state == STOP && bit_done));
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  nxt = empty ? IDLE : START;
      START: nxt = bit_done ? DATA : START;
      DATA:  nxt = (bit_done && idx == 3'(UART_DATA_BITS - 1)) ? STOP : DATA;
      STOP:  nxt = bit_done ? (empty ? IDLE : START) : STOP;
      default: nxt = IDLE;
    endcase
  end
  // line is driven from the current state, so it trails the FSM by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      uart_tx <= 1'b1;
    end else begin
      state <= nxt;
      cnt <= (state == IDLE || bit_done) ? '0 : cnt + 16'd1;
      idx <= state != DATA ? '0 : bit_done ? idx + 3'd1 : idx;
      sh <= pop ? head : (state == DATA && bit_done) ? sh >> 1 : sh;
      uart_tx <= state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;
    end
  end
endmodule

// File: doc/uart_cmd_tx.md
UART_CMD_TX -- requirements
Module: uart_cmd_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, byte FIFO depth; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port ctrl_command_in  input  4  feedback control nibble, transmitted as byte[7:4].
REQ-006 SHALL have port value_command_in  input  4  feedback value nibble, transmitted as byte[3:0].
REQ-007 SHALL have port cmd_valid  input  1  producer offers {ctrl,value} this cycle.
REQ-008 SHALL have port cmd_ready  output  1  block accepts an offer this cycle; equals FIFO not full.
REQ-009 SHALL have port uart_tx  output  1  8N1 serial line to host PC; idle high; registered.
REQ-010 SHALL have port tx_busy  output  1  high while a frame (start..stop) is on the line.
REQ-011 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte in flight.

Function
REQ-012 SHALL push {ctrl_command_in, value_command_in} into the FIFO on every edge where cmd_valid && cmd_ready; cmd_valid with cmd_ready low SHALL be ignored (producer holds).
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-014 IDLE: uart_tx=1; if FIFO non-empty, pop head into shift register, go START.
REQ-015 START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-016 DATA: send 8 bits LSB first, each CLKS_PER_BIT cycles, 3-bit bit index, then STOP.
REQ-017 STOP: uart_tx=1 for CLKS_PER_BIT cycles; at the end, if FIFO non-empty pop and go START directly (no idle gap), else IDLE.
REQ-018 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles; baud counter 16-bit, counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary.
REQ-019 Latency: with FSM in IDLE and FIFO empty, uart_tx SHALL fall on the 2nd rising edge after the accepting edge.
REQ-020 Simultaneous push and pop SHALL be legal; fifo_level unchanged; when full, cmd_ready=0 so no push, pop frees one slot with cmd_ready high the next cycle.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; data order preserved.
REQ-022 tx_busy SHALL be high exactly in START, DATA, STOP.
REQ-023 Inputs are sampled only on accepting edges; changes on the nibble inputs at other times have no effect.

Reset
REQ-024 On rst=1 at a rising edge: uart_tx=1, tx_busy=0, FSM=IDLE, FIFO empty, fifo_level=0, cmd_ready=1 from the next cycle, counters=0.
REQ-025 Reset mid-frame SHALL abort the frame (line high next edge) and discard all queued bytes; no partial frame resumes.

Structure
REQ-026 Package uart_pkg SHALL hold UART_DATA_BITS=8, the FSM state typedef, and CLKS_PER_BIT default, shared with the receive side.
REQ-027 FIFO SHALL be sub-module sync_fifo (params WIDTH=8, DEPTH; push/pop/full/empty/level); FSM, baud counter and shifter stay in uart_cmd_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Single command ctrl=0xA, value=0x5 -> uart_tx low 4 cycles from 2nd edge after accept, bits 1,0,1,0,0,1,0,1 (0xA5 LSB first) 4 cycles each, high 4 cycles; tx_busy high 40 cycles.
REQ-029 Five back-to-back offers 0x11..0x55 with cmd_valid held -> cmd_ready drops when fifo_level=4, all five bytes sent in order, stop of each immediately followed by next start (200 busy cycles contiguous).
REQ-030 Push exactly when STOP pops at full FIFO -> no byte lost or duplicated; fifo_level steady at 4 that cycle-pair.
REQ-031 rst asserted during DATA bit 3 of 0x3C with 2 bytes queued -> uart_tx=1, fifo_level=0, tx_busy=0 next edge; no further frames.
REQ-032 cmd_valid held with cmd_ready=0 and nibbles changing -> only value present on accepting edge is transmitted.
REQ-033 Loopback uart_tx into existing receiver, 16 random bytes -> received sequence identical.
